// File: rtl/cam_seq_pkg.sv
// Shared state encoding and default frame geometry for the camera frame sequencer.
package cam_seq_pkg;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int HSYNC_LEN_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_VSYNC,
        ST_VBLANK,
        ST_LINE,
        ST_HBLANK,
        ST_DONE
    } state_e;

    function automatic logic state_is_vblank(input state_e s);
        return (s != ST_LINE) && (s != ST_HBLANK);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers a raw camera level and derives one-clock rise/fall pulses from the registered copies.
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign rise_o = s1_q & ~s2_q;
    assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/cam_frame_sequencer.sv
// Arms capture per frame, regenerates clean video timing from camera href/vsync and
// flags malformed lines/frames; all outputs registered, pixels lag pix_valid by one clock.
module cam_frame_sequencer
    import cam_seq_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int HSYNC_LEN = HSYNC_LEN_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            single_shot,
    input  logic                            err_clr,
    input  logic                            href,
    input  logic                            vsync,
    input  logic                            pix_valid,
    input  logic [15:0]                     pix_data,
    output logic [15:0]                     vid_data,
    output logic                            vid_ce,
    output logic                            vid_active,
    output logic                            vid_hblank,
    output logic                            vid_hsync,
    output logic                            vid_vblank,
    output logic                            vid_vsync,
    output logic                            frame_done,
    output logic                            line_err,
    output logic                            frame_err,
    output logic                            busy,
    output logic [$clog2(V_ACTIVE+1)-1:0]   line_count
);

    localparam int LC_W = $clog2(V_ACTIVE + 1);
    localparam int PC_W = $clog2(H_ACTIVE + 2);
    localparam int HS_W = $clog2(HSYNC_LEN + 1);

    localparam logic [LC_W-1:0] V_MAX  = LC_W'(V_ACTIVE);
    localparam logic [PC_W-1:0] PC_H   = PC_W'(H_ACTIVE);
    localparam logic [PC_W-1:0] PC_SAT = PC_W'(H_ACTIVE + 1);
    localparam logic [HS_W-1:0] HS_LEN = HS_W'(HSYNC_LEN);

    logic href_rise, href_fall, vs_rise, vs_fall;

    sync_edge u_href_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (href),
        .rise_o (href_rise),
        .fall_o (href_fall)
    );

    sync_edge u_vsync_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (vsync),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    state_e          state_q, state_d;
    logic [PC_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [LC_W-1:0] line_cnt_q, line_cnt_d;
    logic [HS_W-1:0] hs_cnt_q, hs_cnt_d;
    logic            line_err_q, line_err_d;
    logic            frame_err_q, frame_err_d;
    logic            shot_done_q, shot_done_d;

    logic [15:0]     vid_data_q;
    logic            vid_ce_q, vid_hblank_q, vid_hsync_q;
    logic            vid_vblank_q, vid_vsync_q, frame_done_q, busy_q;

    logic            in_frame_line;
    logic            early_vs;
    logic            line_end;
    logic            pix_fwd;

    always_comb begin
        in_frame_line = (state_q == ST_LINE) || (state_q == ST_HBLANK);
        early_vs      = vs_rise && in_frame_line && (line_cnt_q < V_MAX);
        line_end      = (state_q == ST_LINE) && href_fall && !early_vs;
        pix_fwd       = (state_q == ST_LINE) && pix_valid && (pix_cnt_q < PC_H);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A finished single-shot holds IDLE until enable is dropped and raised again.
            ST_IDLE:   if (enable && !shot_done_q) state_d = ST_ARM;
            ST_ARM: begin
                if (!enable)      state_d = ST_IDLE;
                else if (vs_rise) state_d = ST_VSYNC;
            end
            ST_VSYNC:  if (vs_fall) state_d = ST_VBLANK;
            ST_VBLANK: if (href_rise) state_d = ST_LINE;
            ST_LINE: begin
                if (early_vs)       state_d = ST_VSYNC;
                else if (href_fall) state_d = ST_HBLANK;
            end
            ST_HBLANK: begin
                if (line_cnt_q == V_MAX) state_d = ST_DONE;
                else if (early_vs)       state_d = ST_VSYNC;
                else if (href_rise)      state_d = ST_LINE;
            end
            ST_DONE:   state_d = (enable && !single_shot) ? ST_ARM : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (early_vs || line_end)
            pix_cnt_d = '0;
        else if ((state_q == ST_LINE) && pix_valid && (pix_cnt_q != PC_SAT))
            pix_cnt_d = pix_cnt_q + 1'b1;

        line_cnt_d = line_cnt_q;
        if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC))
            line_cnt_d = '0;
        else if (line_end && (line_cnt_q != V_MAX))
            line_cnt_d = line_cnt_q + 1'b1;

        hs_cnt_d = '0;
        if (line_end)
            hs_cnt_d = HS_LEN;
        else if (hs_cnt_q != '0)
            hs_cnt_d = hs_cnt_q - 1'b1;

        // Error events take priority over a coincident clear.
        line_err_d = line_err_q;
        if (line_end && (pix_cnt_q != PC_H)) line_err_d = 1'b1;
        else if (err_clr)                    line_err_d = 1'b0;

        frame_err_d = frame_err_q;
        if (early_vs)     frame_err_d = 1'b1;
        else if (err_clr) frame_err_d = 1'b0;

        shot_done_d = shot_done_q;
        if (!enable)                                   shot_done_d = 1'b0;
        else if ((state_q == ST_DONE) && single_shot)  shot_done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            hs_cnt_q     <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            shot_done_q  <= 1'b0;
            vid_data_q   <= '0;
            vid_ce_q     <= 1'b0;
            vid_hblank_q <= 1'b1;
            vid_hsync_q  <= 1'b0;
            vid_vblank_q <= 1'b1;
            vid_vsync_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            hs_cnt_q     <= hs_cnt_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            shot_done_q  <= shot_done_d;
            if (pix_fwd)
                vid_data_q <= pix_data;
            vid_ce_q     <= pix_fwd;
            vid_hblank_q <= !pix_fwd;
            vid_hsync_q  <= (hs_cnt_d != '0);
            vid_vblank_q <= state_is_vblank(state_d);
            vid_vsync_q  <= (state_d == ST_VSYNC);
            frame_done_q <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign vid_data   = vid_data_q;
    assign vid_ce     = vid_ce_q;
    assign vid_active = vid_ce_q;
    assign vid_hblank = vid_hblank_q;
    assign vid_hsync  = vid_hsync_q;
    assign vid_vblank = vid_vblank_q;
    assign vid_vsync  = vid_vsync_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign line_count = line_cnt_q;

endmodule

// File: doc/cam_frame_sequencer.md
# cam_frame_sequencer

Controller between the OV7670 YUV capture stage and the Video-In-to-AXI4-Stream input of the block design. Qualifies raw `href`/`vsync` from the camera and arms capture per frame, either continuous or single-shot. Regenerates clean, frame-aligned video timing (active/hblank/hsync/vblank/vsync) and counts pixels and lines. Flags malformed lines and frames so only whole frames reach the stream.

## Interface
- `H_ACTIVE`, 640: pixels (16-bit words) per valid line.
- `V_ACTIVE`, 480: lines per valid frame.
- `HSYNC_LEN`, 4: hsync pulse length in clocks, asserted after each line.
- `clk` in 1: camera pixel clock domain. Single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; permits arming.
- `single_shot` in 1: 1 = capture one frame then idle; 0 = continuous.
- `err_clr` in 1: one-cycle pulse; clears sticky error flags.
- `href` in 1: camera line valid, raw.
- `vsync` in 1: camera frame sync, active-high, raw.
- `pix_valid` in 1: one-cycle strobe per assembled pixel from the capture stage.
- `pix_data` in 16: YUV pixel.
- `vid_data` out 16: registered pixel.
- `vid_ce` out 1: pixel strobe to Video In.
- `vid_active` out 1: active video.
- `vid_hblank` out 1: horizontal blank.
- `vid_hsync` out 1: horizontal sync.
- `vid_vblank` out 1: vertical blank.
- `vid_vsync` out 1: vertical sync.
- `frame_done` out 1: one-cycle pulse at the end of a complete frame.
- `line_err` out 1: sticky; a line had a pixel count other than `H_ACTIVE`.
- `frame_err` out 1: sticky; vsync arrived before `V_ACTIVE` lines.
- `busy` out 1: high in every state except IDLE.
- `line_count` out $clog2(V_ACTIVE+1): lines completed in the current frame.

## Operation
- `href`/`vsync` rising and falling edges are taken from registered copies; all decisions use these edges.
- FSM states and transitions:
  - IDLE → ARM when `enable`.
  - ARM → VSYNC on vsync rise. ARM → IDLE if `enable` drops.
  - VSYNC → VBLANK on vsync fall.
  - VBLANK → LINE on href rise.
  - LINE → HBLANK on href fall.
  - HBLANK → LINE on href rise. HBLANK → DONE when `line_count == V_ACTIVE`.
  - DONE → ARM if `enable && !single_shot`; otherwise → IDLE.
- LINE:
  - Pixel counter increments on each `pix_valid`.
  - Pixels 0..H_ACTIVE-1 are forwarded with `vid_ce=1, vid_active=1`.
  - Pixels beyond `H_ACTIVE` are dropped (`vid_ce=0`).
- On href fall:
  - `line_count` increments, saturating at `V_ACTIVE`.
  - If the pixel count is not `H_ACTIVE`, `line_err` is set.
  - The pixel counter clears.
  - `vid_hsync` is high for `HSYNC_LEN` clocks starting the clock after the fall.
- vsync rise in LINE or HBLANK with `line_count < V_ACTIVE`: `frame_err` is set, no `frame_done`, FSM goes directly to VSYNC. The counters clear.
- Lines arriving in DONE/ARM are ignored.
- `enable` dropping mid-frame takes effect only at DONE; a frame in progress always completes or errors.
- `err_clr` and a simultaneous error event in the same clock: the error wins (flag stays set).
- Output levels by state:
  - `vid_vblank` high in IDLE, ARM, VSYNC, VBLANK, DONE.
  - `vid_vsync` high in VSYNC.
  - `vid_hblank` high whenever `vid_active` is low.
- Reset (async, `reset_n` low): state IDLE; all outputs 0 except `vid_hblank=1`, `vid_vblank=1`; counters 0; errors cleared.

## Timing
- All outputs are registered.
- `vid_data`/`vid_ce`/`vid_active` lag `pix_valid` by exactly 1 clock.
- State change is visible on the clock after the registered edge, i.e. 2 clocks after a raw `href`/`vsync` transition.
- `frame_done`:
  - Asserted for 1 clock on entry to DONE, one clock after the final href fall is registered.
  - Continuous mode re-arms in time for the next vsync; DONE lasts exactly 1 clock.
- Back-to-back lines with a 1-clock href low gap are supported, since hsync may overlap the next LINE.

## Structure
- Package `cam_seq_pkg`: state enum (IDLE, ARM, VSYNC, VBLANK, LINE, HBLANK, DONE) and default `H_ACTIVE`/`V_ACTIVE` constants.
- One sub-module, `sync_edge`: register plus rise/fall pulse generator, instanced for `href` and `vsync`.
- Counters and FSM live in the top.

## Test plan
- Nominal frame, 640 px × 480 lines, `single_shot=1`, `enable=1` → 307200 `vid_ce` pulses, one `frame_done`, FSM IDLE, `line_count=480`, no errors.
- Continuous mode, 3 frames → 3 `frame_done` pulses; `busy` stays high; `vid_vsync` asserted once per frame.
- Line of 639 px on line 10, then a line of 642 px → `line_err` sets at the first href fall; 640 `vid_ce` on the long line; `err_clr` clears the flag.
- vsync rise after 200 lines → `frame_err=1`, no `frame_done`, next full frame completes normally.
- `enable` dropped at line 100 → frame completes, `frame_done`, then IDLE. `reset_n` low mid-line → all outputs at reset values immediately, without waiting for a clock edge.
- `HSYNC_LEN=4` with a 2-clock href gap → `vid_hsync` high 4 clocks, overlapping the next line's first pixels; pixel data is unaffected.
